// File: rtl/mem_responder_if.sv
// Request/ack bus and load port between the control unit and mem_responder.
interface mem_responder_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
);
    logic [AWIDTH-1:0] i_addr;
    logic              i_read;
    logic              i_write;
    logic [DWIDTH-1:0] i_wdata;
    logic              i_load_en;
    logic [AWIDTH-1:0] i_load_addr;
    logic [DWIDTH-1:0] i_load_data;
    logic [DWIDTH-1:0] o_rdata;
    logic              o_rd_valid;
    logic              o_wr_done;
    logic              o_busy;
    logic              o_err;

    modport master (
        output i_addr, i_read, i_write, i_wdata,
        output i_load_en, i_load_addr, i_load_data,
        input  o_rdata, o_rd_valid, o_wr_done, o_busy, o_err
    );

    modport slave (
        input  i_addr, i_read, i_write, i_wdata,
        input  i_load_en, i_load_addr, i_load_data,
        output o_rdata, o_rd_valid, o_wr_done, o_busy, o_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits WAIT_STATES cycles,
// accesses the word array and holds a 4-phase ack until the request drops.
module mem_responder #(
    parameter int DWIDTH      = 16,
    parameter int AWIDTH      = 12,
    parameter int WAIT_STATES = 2
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    state_t            state;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [AWIDTH-1:0] lat_addr;
    logic [DWIDTH-1:0] lat_wdata;
    logic [DWIDTH-1:0] rdata;
    logic              rd_valid;
    logic              wr_done;
    logic              err;
    logic              req_any;
    logic              req_both;

    assign req_any  = bus.i_read | bus.i_write;
    assign req_both = bus.i_read & bus.i_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_both) begin
                        err <= 1'b1;
                    end else if (req_any) begin
                        op_wr     <= bus.i_write;
                        lat_addr  <= bus.i_addr;
                        lat_wdata <= bus.i_wdata;
                        cnt       <= WS;
                        state     <= (WS == 4'd0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) state <= ACCESS;
                end
                ACCESS: begin
                    if (!op_wr) rdata <= mem[lat_addr];
                    rd_valid <= ~op_wr;
                    wr_done  <= op_wr;
                    state    <= RESP;
                end
                RESP: begin
                    if (!req_any) begin
                        rd_valid <= 1'b0;
                        wr_done  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; a reset edge suppresses both write sources
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == IDLE && bus.i_load_en)
                mem[bus.i_load_addr] <= bus.i_load_data;
            else if (state == ACCESS && op_wr)
                mem[lat_addr] <= lat_wdata;
        end
    end

    assign bus.o_rdata    = rdata;
    assign bus.o_rd_valid = rd_valid;
    assign bus.o_wr_done  = wr_done;
    assign bus.o_err      = err;
    assign bus.o_busy     = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states,
// one with none, sharing clock and reset.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.DWIDTH(16), .AWIDTH(12)) ba ();
    mem_responder_if #(.DWIDTH(16), .AWIDTH(12)) bb ();

    mem_responder #(
        .DWIDTH(16), .AWIDTH(12), .WAIT_STATES(2)
    ) ua (
        .clk(clk), .reset(reset), .bus(ba)
    );

    mem_responder #(
        .DWIDTH(16), .AWIDTH(12), .WAIT_STATES(0)
    ) ub (
        .clk(clk), .reset(reset), .bus(bb)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit s, input logic rd, input logic wr,
                       input logic [11:0] a, input logic [15:0] d);
        if (s) begin
            bb.i_read = rd; bb.i_write = wr;
            bb.i_addr = a;  bb.i_wdata = d;
        end else begin
            ba.i_read = rd; ba.i_write = wr;
            ba.i_addr = a;  ba.i_wdata = d;
        end
    endtask

    task automatic ld(input bit s, input logic en,
                      input logic [11:0] a, input logic [15:0] d);
        if (s) begin
            bb.i_load_en = en; bb.i_load_addr = a; bb.i_load_data = d;
        end else begin
            ba.i_load_en = en; ba.i_load_addr = a; ba.i_load_data = d;
        end
    endtask

    function automatic logic [15:0] rdata(input bit s);
        return s ? bb.o_rdata : ba.o_rdata;
    endfunction

    function automatic logic ack(input bit s, input bit wr);
        if (s) return wr ? bb.o_wr_done : bb.o_rd_valid;
        return wr ? ba.o_wr_done : ba.o_rd_valid;
    endfunction

    function automatic logic busy(input bit s);
        return s ? bb.o_busy : ba.o_busy;
    endfunction

    task automatic load(input bit s, input logic [11:0] a,
                        input logic [15:0] d);
        ld(s, 1'b1, a, d);
        tick;
        ld(s, 1'b0, 12'h0, 16'h0);
    endtask

    // Full transaction from cycle 0; lat is the expected ack cycle
    task automatic txn(input string tag, input bit s, input bit wr,
                       input logic [11:0] a, input logic [15:0] d,
                       input int lat, input int hold,
                       input logic [15:0] exp_rd);
        int n;
        drv(s, !wr, wr, a, d);
        tick;
        n = 1;
        chk({tag, ".busy"}, 32'(busy(s)), 32'd1);
        while (!ack(s, wr) && n < 20) begin
            tick;
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        if (!wr) chk({tag, ".rdata"}, rdata(s), exp_rd);
        repeat (hold) tick;
        chk({tag, ".held"}, 32'(ack(s, wr)), 32'd1);
        drv(s, 1'b0, 1'b0, a, d);
        tick;
        chk({tag, ".ackfall"}, 32'(ack(s, wr)), 32'd0);
        chk({tag, ".idle"}, 32'(busy(s)), 32'd0);
        if (!wr) chk({tag, ".rdhold"}, rdata(s), exp_rd);
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 12'h0, 16'h0);
        drv(1, 0, 0, 12'h0, 16'h0);
        ld(0, 0, 12'h0, 16'h0);
        ld(1, 0, 12'h0, 16'h0);
        repeat (3) tick;
        chk("rst.rdata", ba.o_rdata, 16'h0);
        chk("rst.rdv", 32'(ba.o_rd_valid), 32'd0);
        chk("rst.wrd", 32'(ba.o_wr_done), 32'd0);
        chk("rst.busy", 32'(ba.o_busy), 32'd0);
        chk("rst.err", 32'(ba.o_err), 32'd0);
        reset = 1'b0;
        tick;

        // load then read with two wait states
        load(0, 12'h123, 16'hBEEF);
        txn("ldrd", 0, 0, 12'h123, 16'h0, 4, 2, 16'hBEEF);

        // write/readback with zero wait states
        txn("b.wr", 1, 1, 12'hFFF, 16'h5A5A, 2, 1, 16'h0);
        txn("b.rd", 1, 0, 12'hFFF, 16'h0, 2, 0, 16'h5A5A);

        // write/readback with two wait states
        txn("a.wr", 0, 1, 12'h0A5, 16'hC3C3, 4, 0, 16'h0);
        txn("a.rd", 0, 0, 12'h0A5, 16'h0, 4, 1, 16'hC3C3);

        // conflicting request
        load(0, 12'h010, 16'h1111);
        drv(0, 1, 1, 12'h010, 16'h2222);
        tick;
        chk("cf.err1", 32'(ba.o_err), 32'd1);
        chk("cf.busy1", 32'(ba.o_busy), 32'd0);
        drv(0, 0, 0, 12'h010, 16'h2222);
        tick;
        chk("cf.err2", 32'(ba.o_err), 32'd0);
        chk("cf.busy2", 32'(ba.o_busy), 32'd0);
        txn("cf.rd", 0, 0, 12'h010, 16'h0, 4, 0, 16'h1111);

        // request changed and dropped during WAIT
        load(0, 12'h001, 16'hAAAA);
        load(0, 12'h002, 16'h5555);
        drv(0, 1, 0, 12'h001, 16'h0);
        tick;
        drv(0, 1, 0, 12'h002, 16'h0);
        tick;
        drv(0, 0, 0, 12'h002, 16'h0);
        tick;
        chk("wc.c3", 32'(ba.o_rd_valid), 32'd0);
        tick;
        chk("wc.c4", 32'(ba.o_rd_valid), 32'd1);
        chk("wc.rdata", ba.o_rdata, 16'hAAAA);
        tick;
        chk("wc.c5", 32'(ba.o_rd_valid), 32'd0);
        chk("wc.busy", 32'(ba.o_busy), 32'd0);
        chk("wc.rdhold", ba.o_rdata, 16'hAAAA);

        // reset during the ACCESS cycle of a write
        load(0, 12'h040, 16'h0000);
        drv(0, 0, 1, 12'h040, 16'h1234);
        repeat (3) tick;
        chk("rw.busy", 32'(ba.o_busy), 32'd1);
        reset = 1'b1;
        drv(0, 0, 0, 12'h040, 16'h1234);
        tick;
        chk("rw.rdata", ba.o_rdata, 16'h0);
        chk("rw.rdv", 32'(ba.o_rd_valid), 32'd0);
        chk("rw.wrd", 32'(ba.o_wr_done), 32'd0);
        chk("rw.busy0", 32'(ba.o_busy), 32'd0);
        chk("rw.err", 32'(ba.o_err), 32'd0);
        reset = 1'b0;
        tick;
        txn("rw.rd", 0, 0, 12'h040, 16'h0, 4, 0, 16'h0000);

        // load port ignored outside IDLE
        load(0, 12'h050, 16'h7777);
        drv(0, 1, 0, 12'h123, 16'h0);
        tick;
        ld(0, 1, 12'h050, 16'h9999);
        tick;
        ld(0, 0, 12'h0, 16'h0);
        repeat (2) tick;
        chk("lg.rdv", 32'(ba.o_rd_valid), 32'd1);
        chk("lg.rdata", ba.o_rdata, 16'hBEEF);
        drv(0, 0, 0, 12'h0, 16'h0);
        tick;
        txn("lg.rd", 0, 0, 12'h050, 16'h0, 4, 0, 16'h7777);

        // load and request in the same IDLE cycle
        load(0, 12'h070, 16'h1111);
        drv(0, 1, 0, 12'h070, 16'h0);
        ld(0, 1, 12'h070, 16'h2222);
        tick;
        ld(0, 0, 12'h0, 16'h0);
        repeat (3) tick;
        chk("sl.rdv", 32'(ba.o_rd_valid), 32'd1);
        chk("sl.rdata", ba.o_rdata, 16'h2222);
        drv(0, 0, 0, 12'h0, 16'h0);
        tick;
        chk("sl.idle", 32'(ba.o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's 12-bit address / 16-bit data memory bus. It accepts read and write requests from the control unit, latches them, and inserts a programmable number of wait states. It then performs the access on an internal 2^AWIDTH x DWIDTH word array and acknowledges with a 4-phase handshake. A bench/boot load port allows the array to be initialised while the bus is idle.

## Interface
- DWIDTH, 16, data word width
- AWIDTH, 12, address width; array depth = 2**AWIDTH words
- WAIT_STATES, 2, wait cycles inserted between request capture and array access (0..15)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_addr  in  AWIDTH  request address
- i_read  in  1  read request (level, held until acknowledged)
- i_write  in  1  write request (level, held until acknowledged)
- i_wdata  in  DWIDTH  write data
- i_load_en  in  1  load-port write strobe
- i_load_addr  in  AWIDTH  load-port address
- i_load_data  in  DWIDTH  load-port data
- o_rdata  out  DWIDTH  read data; registered, held until the next read completes
- o_rd_valid  out  1  read acknowledge
- o_wr_done  out  1  write acknowledge
- o_busy  out  1  high whenever state != IDLE
- o_err  out  1  1-cycle pulse: illegal request (i_read and i_write both high)

## Operation
- States: IDLE, WAIT, ACCESS, RESP. 3-bit state register; 4-bit wait counter.
- IDLE:
  - If exactly one of i_read/i_write is high, latch op, i_addr, i_wdata.
  - Then go to WAIT with counter = WAIT_STATES, or straight to ACCESS if WAIT_STATES = 0.
- IDLE, both i_read and i_write high: pulse o_err for 1 cycle. Stay in IDLE. No access.
- IDLE, i_load_en high: mem[i_load_addr] <= i_load_data. Honoured only in IDLE; ignored in every other state.
- IDLE, load and bus request in the same cycle: both take effect. The request latches the pre-load bus values, and the load write lands in the same edge.
- WAIT:
  - Decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - Bus inputs are ignored. Latched values are used even if the requester changes or drops the request.
- ACCESS, exactly one cycle:
  - Read: o_rdata <= mem[latched addr].
  - Write: mem[latched addr] <= latched wdata.
  - Then go to RESP.
- RESP:
  - o_rd_valid (read) or o_wr_done (write) is held high.
  - Exit to IDLE at the first edge where i_read = 0 and i_write = 0.
  - Minimum RESP length is 1 cycle, so a request dropped early yields a 1-cycle ack pulse.
  - A new request is never captured in RESP. It must pass through IDLE.
- Reset:
  - Sets state = IDLE, counter = 0, o_rdata = 0, o_rd_valid = o_wr_done = o_err = 0. o_busy = 0 follows from state.
  - Reset asserted in the ACCESS cycle aborts the access: no array write, o_rdata stays 0.
  - Array contents are not cleared by reset.
- All addresses are in range; no wrap or out-of-range handling is required.

## Timing
- Cycle 0 = first cycle a legal request is high in IDLE.
- Capture at the end of cycle 0. WAIT occupies cycles 1..W (W = WAIT_STATES). ACCESS is cycle W+1.
- Ack first high in cycle W+2. o_rdata is valid in the same cycle and stays stable afterwards.
- W = 0 means the ack is high in cycle 2. With the default W = 2, the ack is high in cycle 4.
- Ack falls the cycle after the requester drops its request.
- Minimum back-to-back request spacing is W+4 cycles (IDLE → … → RESP → IDLE → capture).
- o_busy rises in cycle 1 and falls in the cycle IDLE is re-entered.
- o_err is high in cycle 1 only, i.e. registered from a cycle-0 conflict.
- Load-port write is visible to a read captured in the following cycle or later.

## Test plan
- Load/read, W=2:
  - Stimulus: load mem[0x123] = 0xBEEF; then hold i_read with i_addr = 0x123.
  - Response: o_rd_valid first high in cycle 4 with o_rdata = 0xBEEF; held until i_read drops; low 1 cycle later.
- Write then read back, W=0:
  - Stimulus: write 0x5A5A to 0xFFF; then read 0xFFF.
  - Response: o_wr_done high in cycle 2; the read returns 0x5A5A in cycle 2 of its own transaction.
- Conflict:
  - Stimulus: i_read = i_write = 1 at addr 0x010, which holds 0x1111.
  - Response: o_err is a 1-cycle pulse; o_busy stays 0; mem[0x010] stays 0x1111.
- Request change in WAIT:
  - Stimulus: read 0x001 (= 0xAAAA); in cycle 1 switch i_addr to 0x002 (= 0x5555) and drop i_read in cycle 2.
  - Response: o_rdata = 0xAAAA; o_rd_valid is a 1-cycle pulse.
- Reset mid-write:
  - Stimulus: write 0x1234 to 0x040 (= 0x0000); assert reset in the ACCESS cycle.
  - Response: mem[0x040] = 0x0000; all outputs 0 next cycle; a fresh read of 0x040 returns 0x0000.
- Load port gating:
  - Stimulus: i_load_en high (addr 0x050, data 0x9999) while in WAIT.
  - Response: ignored; a later read of 0x050 returns the prior contents.
